div_result_fifo: RTL and testbench

Elastic result buffer sitting directly downstream of the restoring divider: it accepts {quotient, remainder} pairs over a valid/ready handshake and holds up to DEPTH of them in order until the consumer takes them. This decouples a slow or stalling consumer from the divider's multi-cycle iteration, so the divider can start the next operand pair as soon as its result is handed over.

---
 rtl/div_result_fifo.sv | 79 +++++++
 tb/tb_div_result_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_fifo.sv
// div_result_fifo: elastic in-order buffer of {quotient, remainder} pairs behind the divider.
// Optional macro DIV_FIFO_BYPASS_EN: an empty buffer forwards a result in the same cycle.
module div_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [WIDTH-1:0]           quotient_in,
  input  logic [WIDTH-1:0]           remainder_in,
  output logic                       dest_valid,
  input  logic                       dest_ready,
  output logic [WIDTH-1:0]           quotient_out,
  output logic [WIDTH-1:0]           remainder_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits for ready, and src_ready depends only on the stored occupancy.
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      occ;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;

  assign empty     = (occ == '0);
  assign full      = (occ == FULL_CNT);
  assign src_ready = !full;
  assign count     = occ;

`ifdef DIV_FIFO_BYPASS_EN
  logic bypass;
  // Gated by reset so outputs stay quiet while the buffer is held in reset.
  assign bypass     = empty & src_valid & reset;
  assign dest_valid = !empty | bypass;
  assign {quotient_out, remainder_out} = bypass ? {quotient_in, remainder_in} : mem[rd_ptr];
  assign push       = src_valid & src_ready & ~(bypass & dest_ready);
  assign pop        = !empty & dest_ready;
`else
  assign dest_valid = !empty;
  assign {quotient_out, remainder_out} = mem[rd_ptr];
  assign push       = src_valid & src_ready;
  assign pop        = dest_valid & dest_ready;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {quotient_in, remainder_in};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_fifo.sv
// Directed bench for div_result_fifo: queue model of the buffer plus hand-computed vectors.
module tb_div_result_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              src_valid;
  logic              src_ready;
  logic [WIDTH-1:0]  quotient_in;
  logic [WIDTH-1:0]  remainder_in;
  logic              dest_valid;
  logic              dest_ready;
  logic [WIDTH-1:0]  quotient_out;
  logic [WIDTH-1:0]  remainder_out;
  logic [2:0]        count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] sent_q[$];
  logic        last_accept = 1'b0;

  div_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .quotient_in  (quotient_in),
    .remainder_in (remainder_in),
    .dest_valid   (dest_valid),
    .dest_ready   (dest_ready),
    .quotient_out (quotient_out),
    .remainder_out(remainder_out),
    .count        (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Compare DUT against the queue model, then advance one clock and update the model.
  task automatic tick(input string tag);
    logic        m_valid;
    logic        m_ready;
    logic        do_push;
    logic        do_pop;
    logic        direct;
    logic [31:0] m_head;
    logic [31:0] in_word;
    #1;
    in_word = {quotient_in, remainder_in};
    m_ready = (exp_q.size() != DEPTH);
    m_valid = (exp_q.size() != 0);
    m_head  = m_valid ? exp_q[0] : 32'h0;
    direct  = 1'b0;
`ifdef DIV_FIFO_BYPASS_EN
    if (reset && exp_q.size() == 0 && src_valid) begin
      m_valid = 1'b1;
      m_head  = in_word;
      direct  = dest_ready;
    end
`endif
    if (!reset) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
    end
    check({tag, "/src_ready"}, 32'(src_ready), 32'(m_ready));
    check({tag, "/dest_valid"}, 32'(dest_valid), 32'(m_valid));
    check({tag, "/count"}, 32'(count), 32'(exp_q.size()));
    if (m_valid) check({tag, "/data"}, {quotient_out, remainder_out}, m_head);
    do_push = reset && src_valid && m_ready && !direct;
    do_pop  = reset && m_valid && dest_ready && !direct;
    @(posedge clk);
    last_accept = do_push || direct;
    if (direct) got_q.push_back(in_word);
    if (do_pop) got_q.push_back(exp_q.pop_front());
    if (do_push) exp_q.push_back(in_word);
    #1;
  endtask

  // driver tasks
  task automatic push_pair(input string tag, input logic [15:0] q, input logic [15:0] r);
    int n;
    src_valid    = 1'b1;
    quotient_in  = q;
    remainder_in = r;
    n = 0;
    last_accept = 1'b0;
    while (!last_accept && n < 20) begin
      tick(tag);
      n++;
    end
    if (!last_accept) check({tag, "/accept_timeout"}, 32'd0, 32'd1);
    src_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    src_valid  = 1'b0;
    dest_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick(tag);
      n++;
    end
    tick(tag);
    check({tag, "/empty_after_drain"}, 32'(dest_valid), 32'd0);
  endtask

  task automatic check_got(input string tag, input logic [31:0] exp_v[$]);
    check({tag, "/got_size"}, 32'(got_q.size()), 32'(exp_v.size()));
    for (int i = 0; i < exp_v.size() && i < got_q.size(); i++) begin
      check($sformatf("%s/got%0d", tag, i), got_q[i], exp_v[i]);
    end
  endtask

  initial begin
    logic [31:0] exp_v[$];
    int          sent;
    logic        need_new;

    // reset held with random inputs
    reset = 1'b0;
    src_valid = 1'b0; dest_ready = 1'b0; quotient_in = '0; remainder_in = '0;
    for (int i = 0; i < 3; i++) begin
      src_valid    = 1'($urandom_range(0, 1));
      dest_ready   = 1'($urandom_range(0, 1));
      quotient_in  = 16'($urandom_range(0, 65535));
      remainder_in = 16'($urandom_range(0, 65535));
      tick("rst_hold");
      check("rst_q_out", 32'(quotient_out), 32'd0);
      check("rst_r_out", 32'(remainder_out), 32'd0);
    end
    src_valid = 1'b0; dest_ready = 1'b0;
    reset = 1'b1;
    tick("idle");

    // single pass
    got_q.delete();
    src_valid = 1'b1; quotient_in = 16'h0007; remainder_in = 16'h0002; dest_ready = 1'b1;
`ifdef DIV_FIFO_BYPASS_EN
    #1;
    check("single_bypass_valid", 32'(dest_valid), 32'd1);
    check("single_bypass_q", 32'(quotient_out), 32'h7);
    check("single_bypass_r", 32'(remainder_out), 32'h2);
    tick("single");
    src_valid = 1'b0;
    #1;
`else
    tick("single");
    src_valid = 1'b0;
    #1;
    check("single_valid", 32'(dest_valid), 32'd1);
    check("single_q", 32'(quotient_out), 32'h7);
    check("single_r", 32'(remainder_out), 32'h2);
    tick("single_pop");
`endif
    check("single_empty_valid", 32'(dest_valid), 32'd0);
    check("single_empty_count", 32'(count), 32'd0);
    exp_v = '{32'h0007_0002};
    check_got("single", exp_v);

    // fill / drain with a held 5th result
    got_q.delete();
    dest_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_pair("fill", 16'(i), 16'(i + 16'h100));
    src_valid = 1'b1; quotient_in = 16'd5; remainder_in = 16'h105;
    tick("full_hold");
    tick("full_hold");
    check("full_no_accept", 32'(last_accept), 32'd0);
    check("full_src_ready", 32'(src_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    dest_ready = 1'b1;
    tick("full_pop");
    check("full_pop_only", 32'(last_accept), 32'd0);
    check("full_pop_count", 32'(count), 32'd3);
    tick("fifth_push");
    check("fifth_accepted", 32'(last_accept), 32'd1);
    check("fifth_count", 32'(count), 32'd3);
    drain("fill_drain");
    exp_v = '{32'h0001_0101, 32'h0002_0102, 32'h0003_0103, 32'h0004_0104, 32'h0005_0105};
    check_got("fill", exp_v);

    // simultaneous push/pop at count 2
    got_q.delete();
    dest_ready = 1'b0;
    push_pair("sim", 16'h000A, 16'h0001);
    push_pair("sim", 16'h000B, 16'h0002);
    src_valid = 1'b1; quotient_in = 16'h000C; remainder_in = 16'h0003; dest_ready = 1'b1;
    tick("sim_both");
    check("sim_count", 32'(count), 32'd2);
    drain("sim_drain");
    exp_v = '{32'h000A_0001, 32'h000B_0002, 32'h000C_0003};
    check_got("sim", exp_v);

    // asynchronous reset with 3 stored entries
    dest_ready = 1'b0;
    push_pair("prerst", 16'h1111, 16'h0001);
    push_pair("prerst", 16'h2222, 16'h0002);
    push_pair("prerst", 16'h3333, 16'h0003);
    check("prerst_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(dest_valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick("post_rst");

    // wrap-around: 20 transactions, random consumer
    got_q.delete();
    sent_q.delete();
    sent = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 400 && !(sent == 20 && exp_q.size() == 0); cyc++) begin
      dest_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        if (need_new) begin
          quotient_in  = 16'($urandom_range(0, 65535));
          remainder_in = 16'($urandom_range(0, 65535));
        end
        src_valid = 1'b1;
      end else begin
        src_valid = 1'b0;
      end
      tick("wrap");
      check("wrap_count_max", 32'(count <= 3'd4), 32'd1);
      need_new = last_accept;
      if (last_accept) begin
        sent_q.push_back({quotient_in, remainder_in});
        sent++;
      end
    end
    src_valid = 1'b0;
    check("wrap_all_sent", 32'(sent), 32'd20);
    check("wrap_all_drained", 32'(exp_q.size()), 32'd0);
    check_got("wrap", sent_q);

    // divider results 100/7 and 65535/3 with a stalled consumer
    got_q.delete();
    dest_ready = 1'b0;
    push_pair("div", 16'd14, 16'd2);
    push_pair("div", 16'd21845, 16'd0);
    for (int i = 0; i < 10; i++) tick("div_stall");
    check("div_stall_count", 32'(count), 32'd2);
    drain("div_drain");
    exp_v = '{{16'd14, 16'd2}, {16'd21845, 16'd0}};
    check_got("div", exp_v);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
